// File: rtl/spi_pkg.sv
//------------------------------------------------------------------------------
// spi_pkg
// Shared FSM state type, synchronizer depth and counter sizing for spi_responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int SYNC_STAGES = 2;

  function automatic int cnt_width(input int data_width);
    return $clog2(data_width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_input_sync.sv
//------------------------------------------------------------------------------
// spi_input_sync
// N-flop synchronizer per bit, with a history flop and registered rise/fall strobes.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_input_sync
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter int               STAGES    = SYNC_STAGES,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]             prev_q, prev_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;

  always_comb begin
    sync_d[0] = async_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~prev_q;
    fall_d = ~sync_q[STAGES-1] & prev_q;
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // level is the history flop so it lines up with the strobes
  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

`default_nettype wire

// File: rtl/spi_responder.sv
//------------------------------------------------------------------------------
// spi_responder
// SPI mode-0 responder on the system clock with a one-word TX holding buffer.
// SPI_RESPONDER_LSB_FIRST_EN selects LSB-first in both directions.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_responder
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TX_IDLE    = 0
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int                    CW        = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0]         LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = DATA_WIDTH'(TX_IDLE);
`ifdef SPI_RESPONDER_LSB_FIRST_EN
  localparam int                    OUT_IDX   = 0;
`else
  localparam int                    OUT_IDX   = DATA_WIDTH - 1;
`endif

  logic [2:0] sync_level, sync_rise, sync_fall;
  logic       sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
  logic       unused_sync;

  spi_input_sync #(
    .WIDTH     (3),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (3'b010)
  ) u_input_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .async_in ({spi_mosi, spi_cs_n, spi_sck}),
    .level    (sync_level),
    .rise     (sync_rise),
    .fall     (sync_fall)
  );

  assign sck_rise    = sync_rise[0];
  assign sck_fall    = sync_fall[0];
  assign cs_rise     = sync_rise[1];
  assign cs_fall     = sync_fall[1];
  assign mosi_s      = sync_level[2];
  assign unused_sync = ^{sync_rise[2], sync_fall[2], sync_level[1:0]};

  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  reload_q, reload_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  busy_q, busy_d;
  logic                  miso_q, miso_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_empty_q, buf_empty_d;

  logic [DATA_WIDTH-1:0] next_word, rx_next, tx_shifted;
  logic                  start_word, consume;

  assign next_word = buf_empty_q ? IDLE_WORD : buf_q;
`ifdef SPI_RESPONDER_LSB_FIRST_EN
  assign rx_next    = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
  assign tx_shifted = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
`else
  assign rx_next    = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
  assign tx_shifted = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
`endif

  // A word starts at select, or on the falling edge right after a word completes
  assign start_word = ((state_q == IDLE) && cs_fall) ||
                      ((state_q == SHIFT) && !cs_rise && sck_fall && reload_q);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    reload_d    = reload_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    busy_d      = busy_q;
    miso_d      = miso_q;
    buf_d       = buf_q;
    buf_empty_d = buf_empty_q;
    consume     = 1'b0;

    if (start_word) begin
      tx_shift_d = next_word;
      miso_d     = next_word[OUT_IDX];
      underrun_d = buf_empty_q;
      consume    = !buf_empty_q;
      reload_d   = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = SHIFT;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          miso_d    = 1'b0;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = rx_next;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d  = rx_next;
              rx_valid_d = 1'b1;
              bit_cnt_d  = '0;
              reload_d   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          if (sck_fall && !reload_q) begin
            tx_shift_d = tx_shifted;
            miso_d     = tx_shifted[OUT_IDX];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (tx_valid && buf_empty_q) begin
      buf_d       = tx_data;
      buf_empty_d = 1'b0;
    end else if (consume) begin
      buf_empty_d = 1'b1;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      reload_q    <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      miso_q      <= 1'b0;
      buf_q       <= '0;
      buf_empty_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      reload_q    <= reload_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      busy_q      <= busy_d;
      miso_q      <= miso_d;
      buf_q       <= buf_d;
      buf_empty_q <= buf_empty_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = busy_q;
  assign tx_ready    = buf_empty_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_responder.sv
//------------------------------------------------------------------------------
// tb_spi_responder
// Directed SPI master stimulus against an event-scheduled model of spi_responder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_responder;

  localparam int W = 8;
  // One edge to sample a pin change, then three cycles to the visible output
  localparam int LAT = 1 + 3;
  localparam logic [W-1:0] TX_IDLE_W = '0;

  logic         clock_in = 1'b0;
  logic         reset    = 1'b1;
  logic         spi_sck  = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         spi_miso, spi_miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [W-1:0] tx_data  = '0;
  logic         tx_valid = 1'b0;
  logic [W-1:0] rx_data;

  spi_responder #(.DATA_WIDTH(W), .TX_IDLE(0)) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_underrun (tx_underrun),
    .busy        (busy)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc++;

  // Model: effects scheduled by absolute cycle, plus output levels
  bit           sched_rxv[int];
  logic [W-1:0] sched_rxd[int];
  bit           sched_und[int];
  bit           sched_busy[int];
  bit           sched_ready[int];
  bit           exp_busy  = 1'b0;
  bit           exp_ready = 1'b1;
  logic [W-1:0] exp_rxd   = '0;
  logic [W-1:0] txq[$];
  logic [W-1:0] exp_tx    = '0;
  int           rxv_cycles[$];
  int           und_count = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    sched_rxv.delete();
    sched_rxd.delete();
    sched_und.delete();
    sched_busy.delete();
    sched_ready.delete();
    txq.delete();
    exp_busy  = 1'b0;
    exp_ready = 1'b1;
    exp_rxd   = '0;
  endtask

  initial begin
    forever begin
      @(posedge clock_in);
      #2;
      if (sched_busy.exists(cyc))  exp_busy  = sched_busy[cyc];
      if (sched_ready.exists(cyc)) exp_ready = sched_ready[cyc];
      if (sched_rxd.exists(cyc))   exp_rxd   = sched_rxd[cyc];
      check("rx_valid", rx_valid, sched_rxv.exists(cyc));
      check("rx_data", rx_data, exp_rxd);
      check("tx_underrun", tx_underrun, sched_und.exists(cyc));
      check("busy", busy, exp_busy);
      check("miso_oe", spi_miso_oe, exp_busy);
      check("tx_ready", tx_ready, exp_ready);
      if (!exp_busy) check("miso_idle", spi_miso, 1'b0);
      if (rx_valid) rxv_cycles.push_back(cyc);
      if (tx_underrun) und_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  function automatic int bit_idx(input int i);
`ifdef SPI_RESPONDER_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  task automatic word_start(input int at);
    if (txq.size() == 0) begin
      exp_tx        = TX_IDLE_W;
      sched_und[at] = 1'b1;
    end else begin
      exp_tx          = txq.pop_front();
      sched_ready[at] = 1'b1;
    end
  endtask

  task automatic load_tx(input logic [W-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    sched_ready[cyc+1] = 1'b0;
    txq.push_back(d);
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic cs_assert();
    spi_cs_n = 1'b0;
    sched_busy[cyc+LAT] = 1'b1;
    word_start(cyc + LAT);
    tick(8);
  endtask

  // SCK = clock_in/8; last word ends with SCK fall and CS rise together
  task automatic send_word(input logic [W-1:0] mo, input bit last, input int nbits,
                           output logic [W-1:0] got);
    logic [W-1:0] want;
    want = exp_tx;
    got  = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[bit_idx(i)];
      tick(4);
      got[bit_idx(i)] = spi_miso;
      spi_sck = 1'b1;
      if (i == W - 1) begin
        sched_rxv[cyc+LAT] = 1'b1;
        sched_rxd[cyc+LAT] = mo;
      end
      tick(4);
      spi_sck = 1'b0;
      if (i == nbits - 1 && last) begin
        spi_cs_n = 1'b1;
        sched_busy[cyc+LAT] = 1'b0;
      end else if (i == W - 1) begin
        word_start(cyc + LAT);
      end
    end
    if (nbits == W) check("miso_word", got, want);
    if (last) tick(8);
  endtask

  logic [W-1:0] got, got2;
  int           n_rxv, n_und;

  initial begin
    tick(4);
    check("reset_tx_ready", tx_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_rx_data", rx_data, 8'h00);
    reset = 1'b0;
    tick(4);

    // Single word
    load_tx(8'hA5);
    check("tx_ready_after_load", tx_ready, 1'b0);
    n_rxv = rxv_cycles.size();
    cs_assert();
    check("tx_ready_after_cs_fall", tx_ready, 1'b1);
    send_word(8'h3C, 1'b1, W, got);
    check("single_miso_bits", got, 8'hA5);
    check("single_rx_data", rx_data, 8'h3C);
    check("single_rx_pulses", rxv_cycles.size() - n_rxv, 1);

    // Back-to-back, two words in one select
    load_tx(8'h11);
    n_rxv = rxv_cycles.size();
    cs_assert();
    load_tx(8'h22);
    send_word(8'hC3, 1'b0, W, got);
    send_word(8'h5E, 1'b1, W, got2);
    check("b2b_miso_word1", got, 8'h11);
    check("b2b_miso_word2", got2, 8'h22);
    check("b2b_rx_pulses", rxv_cycles.size() - n_rxv, 2);
    if (rxv_cycles.size() >= 2)
      check("b2b_rx_spacing", rxv_cycles[$] - rxv_cycles[$-1], 64);
    check("b2b_rx_data", rx_data, 8'h5E);

    // Underrun
    n_und = und_count;
    cs_assert();
    send_word(8'h69, 1'b1, W, got);
    check("underrun_miso", got, 8'h00);
    check("underrun_pulses", und_count - n_und, 1);
    check("underrun_rx_data", rx_data, 8'h69);

    // Abort after five rising edges
    n_rxv = rxv_cycles.size();
    cs_assert();
    send_word(8'h12, 1'b1, 5, got);
    check("abort_busy", busy, 1'b0);
    check("abort_oe", spi_miso_oe, 1'b0);
    check("abort_rx_data", rx_data, 8'h69);
    check("abort_no_rx", rxv_cycles.size() - n_rxv, 0);
    cs_assert();
    send_word(8'hF0, 1'b1, W, got);
    check("after_abort_rx", rx_data, 8'hF0);

    // Reset mid-word with a full holding buffer
    cs_assert();
    load_tx(8'h33);
    send_word(8'h77, 1'b0, 3, got);
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    reset    = 1'b1;
    model_reset();
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_oe", spi_miso_oe, 1'b0);
    check("async_rst_miso", spi_miso, 1'b0);
    check("async_rst_tx_ready", tx_ready, 1'b1);
    check("async_rst_rx_data", rx_data, 8'h00);
    check("async_rst_rx_valid", rx_valid, 1'b0);
    check("async_rst_underrun", tx_underrun, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(4);
    load_tx(8'h5A);
    cs_assert();
    send_word(8'h96, 1'b1, W, got);
    check("after_reset_miso", got, 8'h5A);
    check("after_reset_rx", rx_data, 8'h96);

`ifdef SPI_RESPONDER_LSB_FIRST_EN
    load_tx(8'h80);
    cs_assert();
    send_word(8'h01, 1'b1, W, got);
    check("lsb_miso", got, 8'h80);
    check("lsb_rx", rx_data, 8'h01);
`endif

    tick(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
